// File: rtl/cla_seq_adder_pkg.sv
// Shared types and constants for the chunked sequential adder.
//   state_e : controller states (idle, running chunks, result held)
//   CHUNK_W : width of the shared cla_16 datapath
package cla_seq_adder_pkg;

  localparam int unsigned CHUNK_W = 16;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_e;

endpackage

// File: rtl/cla_16.sv
// 16-bit two-level carry-lookahead adder: four 4-bit groups with group
// propagate/generate, and a second lookahead level for the group carries.
//   a, b : operands
//   cin  : carry in
//   sum  : a + b + cin (low 16 bits)
//   cout : carry out of bit 15
module cla_16 (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        cin,
  output logic [15:0] sum,
  output logic        cout
);

  logic [15:0] w_p;
  logic [15:0] w_g;
  logic [3:0]  w_gp;
  logic [3:0]  w_gg;
  logic [4:0]  w_gc;

  assign w_p = a ^ b;
  assign w_g = a & b;

  always_comb begin
    w_gp = '0;
    w_gg = '0;
    for (int j = 0; j < 4; j++) begin
      w_gp[j] = &w_p[4*j +: 4];
      w_gg[j] = w_g[4*j+3]
              | (w_p[4*j+3] & w_g[4*j+2])
              | (w_p[4*j+3] & w_p[4*j+2] & w_g[4*j+1])
              | (w_p[4*j+3] & w_p[4*j+2] & w_p[4*j+1] & w_g[4*j]);
    end
  end

  // Group carries are flattened so no group waits on the previous one.
  assign w_gc[0] = cin;
  assign w_gc[1] = w_gg[0] | (w_gp[0] & cin);
  assign w_gc[2] = w_gg[1] | (w_gp[1] & w_gg[0]) | (w_gp[1] & w_gp[0] & cin);
  assign w_gc[3] = w_gg[2] | (w_gp[2] & w_gg[1]) | (w_gp[2] & w_gp[1] & w_gg[0])
                 | (w_gp[2] & w_gp[1] & w_gp[0] & cin);
  assign w_gc[4] = w_gg[3] | (w_gp[3] & w_gg[2]) | (w_gp[3] & w_gp[2] & w_gg[1])
                 | (w_gp[3] & w_gp[2] & w_gp[1] & w_gg[0])
                 | (w_gp[3] & w_gp[2] & w_gp[1] & w_gp[0] & cin);

  assign cout = w_gc[4];

  always_comb begin : g_bits
    logic c;
    c   = 1'b0;
    sum = '0;
    for (int j = 0; j < 4; j++) begin
      c = w_gc[j];
      for (int i = 0; i < 4; i++) begin
        sum[4*j+i] = w_p[4*j+i] ^ c;
        c          = w_g[4*j+i] | (w_p[4*j+i] & c);
      end
    end
  end

endmodule

// File: rtl/cla_seq_adder.sv
// Multi-cycle WIDTH-bit adder/subtractor that time-shares one cla_16,
// processing one 16-bit chunk per cycle, least-significant chunk first.
//   clk, rst_n          : clock, async active-low reset
//   in_valid / in_ready : request handshake (ready only in idle)
//   a, b, cin, sub      : operands; sub=1 computes a-b (cin ignored)
//   out_valid/out_ready : result handshake; result held until accepted
//   sum, cout, overflow : result, final carry (1 = no borrow on sub), signed overflow
module cla_seq_adder
  import cla_seq_adder_pkg::*;
#(
  parameter int unsigned WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow
);

  localparam int unsigned CHUNKS = WIDTH / CHUNK_W;
  localparam int unsigned CW     = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
  localparam logic [CW-1:0] LastChunk = CW'(CHUNKS - 1);

  state_e                           r_state;
  logic [CHUNKS-1:0][CHUNK_W-1:0]   r_a;
  logic [CHUNKS-1:0][CHUNK_W-1:0]   r_b;   // already inverted for subtract
  logic [CHUNKS-1:0][CHUNK_W-1:0]   r_sum;
  logic                             r_carry;
  logic [CW-1:0]                    r_cnt;
  logic                             r_cout;
  logic                             r_ovf;
  logic                             r_out_valid;

  logic [CHUNK_W-1:0] w_chunk_sum;
  logic               w_chunk_cout;

  // Datapath inputs come only from registers: no a/b -> sum combinational path.
  cla_16 u_cla (
    .a    (r_a[r_cnt]),
    .b    (r_b[r_cnt]),
    .cin  (r_carry),
    .sum  (w_chunk_sum),
    .cout (w_chunk_cout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= StIdle;
      r_a         <= '0;
      r_b         <= '0;
      r_sum       <= '0;
      r_carry     <= 1'b0;
      r_cnt       <= '0;
      r_cout      <= 1'b0;
      r_ovf       <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (in_valid) begin
            r_a     <= a;
            r_b     <= b ^ {WIDTH{sub}};
            r_carry <= sub | cin;
            r_cnt   <= '0;
            r_state <= StRun;
          end
        end
        StRun: begin
          r_sum[r_cnt] <= w_chunk_sum;
          r_carry      <= w_chunk_cout;
          if (r_cnt == LastChunk) begin
            r_cout      <= w_chunk_cout;
            // Sign of the result comes straight from the top chunk's sum.
            r_ovf       <= (r_a[CHUNKS-1][CHUNK_W-1] == r_b[CHUNKS-1][CHUNK_W-1]) &&
                           (w_chunk_sum[CHUNK_W-1] != r_a[CHUNKS-1][CHUNK_W-1]);
            r_out_valid <= 1'b1;
            r_state     <= StDone;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        StDone: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= StIdle;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign in_ready  = (r_state == StIdle);
  assign out_valid = r_out_valid;
  assign sum       = r_sum;
  assign cout      = r_cout;
  assign overflow  = r_ovf;

endmodule

// File: doc/cla_seq_adder.md
Name: cla_seq_adder

Overview:
Multi-cycle wide adder/subtractor controller that time-shares one cla_16 instance. It processes a WIDTH-bit operation one 16-bit chunk per cycle, least-significant chunk first, and threads the carry between chunks through a register. The block sits between a requester using a valid/ready handshake and the cla_16 datapath. It supplies the adder for datapaths wider than 16 bits without instantiating multiple cla_16 blocks.

Parameters:
WIDTH, 64, operand/result width; must be a multiple of 16 and at least 16.
CHUNKS, WIDTH/16, derived number of 16-bit passes; not overridable.
CW, max(1,$clog2(CHUNKS)), derived chunk-counter width.

Ports:
clk  input  1  single clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
in_valid  input  1  request valid.
in_ready  output  1  block can accept a request.
a  input  WIDTH  operand A.
b  input  WIDTH  operand B.
cin  input  1  carry-in for add; ignored when sub=1.
sub  input  1  1 = A-B (B inverted, carry-in forced 1).
out_valid  output  1  result valid.
out_ready  input  1  consumer accepts result.
sum  output  WIDTH  result.
cout  output  1  carry-out of MSB. For sub, 1 means no borrow.
overflow  output  1  signed overflow.

Behaviour:
- States: IDLE, RUN, DONE. The reset state is IDLE.
- Reset values: out_valid=0, sum=0, cout=0, overflow=0, chunk counter=0, carry reg=0, operand regs=0. in_ready=(state==IDLE), so in_ready=1 while in reset.
- IDLE: in_ready=1. When in_valid=1, register a, b^{WIDTH{sub}}, carry=(sub?1:cin), and the MSBs needed for overflow. Set counter=0 and go to RUN.
- RUN: in_ready=0. Each cycle the cla_16 receives a_reg[16k+:16], b_reg[16k+:16] and the carry reg, with k = counter.
  - sum_reg[16k+:16] takes the cla_16 sum; the carry reg takes the cla_16 cout.
  - When k==CHUNKS-1, go to DONE. Otherwise increment k.
- Latency: out_valid rises exactly CHUNKS cycles after the accepting edge (4 for WIDTH=64).
- DONE: out_valid=1. sum, cout and overflow are held stable and in_ready=0.
  - When out_ready=1, go to IDLE and clear out_valid.
  - A new request is not accepted in the same cycle; the next accept is possible one cycle later.
- out_valid is never asserted combinationally from inputs. sum, cout and overflow change only in RUN or on reset.
- cout is the final carry reg.
- overflow = (a_msb == b_eff_msb) && (sum_msb != a_msb), where b_eff is the post-inversion B.
- in_valid during RUN or DONE is ignored; the requester must hold the request until in_ready.
- Reset mid-operation (RUN or DONE) aborts: return to IDLE with all reset values, and the partial result is discarded.
- The cla_16 inputs are driven from registers only, so there is no combinational path from a/b to sum.
- For WIDTH=16, CHUNKS=1: a single RUN cycle.

Decomposition:
- The package holds the state enum (IDLE/RUN/DONE) and CHUNK_W=16.
- The only sub-module is the existing cla_16, instantiated once as the shared datapath.
- Counter, FSM and result register are local. No further sub-module.

Test Plan:
1. WIDTH=64, add: a=0xFFFF_FFFF_FFFF_FFFF, b=0x1, cin=0 -> sum=0, cout=1, overflow=0; out_valid exactly 4 cycles after accept.
2. Inter-chunk carry: a=0x0000_0000_FFFF_FFFF, b=0, cin=1 -> sum=0x0000_0001_0000_0000, cout=0.
3. Subtract: a=5, b=7, sub=1 -> sum=0xFFFF_FFFF_FFFF_FFFE, cout=0. Then a=7, b=5 -> sum=2, cout=1, with cin=1 on the input having no effect.
4. Overflow: a=0x7FFF_FFFF_FFFF_FFFF, b=1 -> sum=0x8000_0000_0000_0000, overflow=1. Also a=0x8000_0000_0000_0000, b=1, sub=1 -> overflow=1.
5. Backpressure: hold out_ready=0 for 3 cycles in DONE -> sum stable, in_ready=0, and a new in_valid is ignored. On out_ready=1 -> IDLE, then accept the next request one cycle later.
6. Assert rst_n=0 during the 2nd RUN cycle -> out_valid=0, sum=0, in_ready=1 immediately. A following a=1, b=2 then yields sum=3 with correct 4-cycle latency.
